// File: rtl/ppu_pipeline_sequencer.sv
// EX/MEM/WB control-word pipeline with load-use bubble insertion and memory-wait freeze; one stage per cycle.
// Backpressure: mem_ready low freezes every stage and drops pc_le/ifid_le; a timeout drops the access.
`timescale 1ns/1ps
module ppu_pipeline_sequencer #(
   parameter int MAX_WAIT    = 16,
   parameter bit HALT_ON_ERR = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [14:0] id_ctrl,
   input  logic        id_valid,
   input  logic        id_squash,
   input  logic [4:0]  id_rs,
   input  logic [4:0]  id_rt,
   input  logic [4:0]  id_rd,
   input  logic        mem_ready,
   output logic        pc_le,
   output logic        ifid_le,
   output logic [14:0] ex_ctrl,
   output logic [14:0] mem_ctrl,
   output logic [14:0] wb_ctrl,
   output logic [4:0]  ex_rd,
   output logic [4:0]  mem_rd,
   output logic [4:0]  wb_rd,
   output logic        mem_req,
   output logic        wb_we,
   output logic        mem_error,
   output logic [15:0] stall_cycles
);

   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

   localparam logic [1:0] ST_RUN      = 2'd0;
   localparam logic [1:0] ST_MEM_WAIT = 2'd1;
   localparam logic [1:0] ST_HALT     = 2'd2;

   typedef struct packed {
      logic        v;
      logic [14:0] ctrl;
      logic [4:0]  rd;
   } stage_t;

   stage_t        ex_s, mem_s, wb_s, id_s, ex_nxt;
   logic [1:0]    state, state_n;
   logic [CW-1:0] wait_cnt, wait_cnt_n;
   logic          lu, mw, adv, drop_wb, err_set, pc_le_c;

   assign ex_ctrl  = ex_s.ctrl;
   assign mem_ctrl = mem_s.ctrl;
   assign wb_ctrl  = wb_s.ctrl;
   assign ex_rd    = ex_s.rd;
   assign mem_rd   = mem_s.rd;
   assign wb_rd    = wb_s.rd;

   // A halted pipeline must not keep the memory busy with the dropped access.
   assign mem_req = mem_s.v & (mem_s.ctrl[0] | mem_s.ctrl[10]) & (state != ST_HALT);
   assign wb_we   = wb_s.v & (wb_s.ctrl[9] | wb_s.ctrl[10]);

   assign lu = ex_s.v & ex_s.ctrl[10] & (ex_s.rd != 5'd0) & id_valid &
               ((ex_s.rd == id_rs) | (ex_s.rd == id_rt));
   assign mw = mem_req & ~mem_ready;

   assign id_s   = (id_valid & ~id_squash) ? '{v: 1'b1, ctrl: id_ctrl, rd: id_rd} : '0;
   // ID only enters EX when IF/ID is released, otherwise it would issue twice.
   assign ex_nxt = pc_le_c ? id_s : '0;

   assign pc_le   = pc_le_c;
   assign ifid_le = pc_le_c;

   always_comb begin
      state_n    = state;
      wait_cnt_n = wait_cnt;
      adv        = 1'b0;
      drop_wb    = 1'b0;
      err_set    = 1'b0;
      pc_le_c    = 1'b0;
      case (state)
         ST_RUN: begin
            if (mw) begin
               state_n    = ST_MEM_WAIT;
               wait_cnt_n = CW'(1);
            end else begin
               adv     = 1'b1;
               pc_le_c = ~lu;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_ready) begin
               adv     = 1'b1;
               pc_le_c = ~lu;
               state_n = ST_RUN;
            end else if (wait_cnt < WAIT_MAX) begin
               wait_cnt_n = wait_cnt + CW'(1);
            end else begin
               adv     = 1'b1;
               drop_wb = 1'b1;
               err_set = 1'b1;
               pc_le_c = ~lu & ~HALT_ON_ERR;
               state_n = HALT_ON_ERR ? ST_HALT : ST_RUN;
            end
         end
         default: begin
            state_n = state;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_s         <= '0;
         mem_s        <= '0;
         wb_s         <= '0;
         state        <= ST_RUN;
         wait_cnt     <= '0;
         mem_error    <= 1'b0;
         stall_cycles <= 16'd0;
      end else begin
         state    <= state_n;
         wait_cnt <= wait_cnt_n;
         if (adv) begin
            ex_s  <= ex_nxt;
            mem_s <= ex_s;
            wb_s  <= drop_wb ? '0 : mem_s;
         end
         if (err_set)
            mem_error <= 1'b1;
         if (!pc_le_c && stall_cycles != 16'hFFFF)
            stall_cycles <= stall_cycles + 16'd1;
      end
   end

endmodule

// File: tb/tb_ppu_pipeline_sequencer.sv
// Directed bench: table of per-cycle vectors plus hand sequences for memory wait, timeout and reset.
`timescale 1ns/1ps
module tb_ppu_pipeline_sequencer;

   localparam logic [14:0] NOP  = 15'h0000;
   localparam logic [14:0] ADDU = 15'h1200;  // alu_op=010, rf_en
   localparam logic [14:0] LBU  = 15'h0601;  // load, rf_en, mem_en
   localparam logic [14:0] SB   = 15'h0011;  // mem_rw, mem_en
   localparam logic T = 1'b1;
   localparam logic F = 1'b0;

   logic        clk, rst_n;
   logic [14:0] id_ctrl;
   logic        id_valid, id_squash, mem_ready;
   logic [4:0]  id_rs, id_rt, id_rd;

   logic        pc_le, ifid_le, mem_req, wb_we, mem_error;
   logic [14:0] ex_ctrl, mem_ctrl, wb_ctrl;
   logic [4:0]  ex_rd, mem_rd, wb_rd;
   logic [15:0] stall_cycles;

   logic        h_pc_le, h_ifid_le, h_mem_req, h_wb_we, h_mem_error;
   logic [14:0] h_ex_ctrl, h_mem_ctrl, h_wb_ctrl;
   logic [4:0]  h_ex_rd, h_mem_rd, h_wb_rd;
   logic [15:0] h_stall_cycles;

   int n_chk = 0;
   int n_err = 0;

   ppu_pipeline_sequencer #(.MAX_WAIT(4), .HALT_ON_ERR(1'b0)) u_dut (
      .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_valid(id_valid), .id_squash(id_squash),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .mem_ready(mem_ready),
      .pc_le(pc_le), .ifid_le(ifid_le), .ex_ctrl(ex_ctrl), .mem_ctrl(mem_ctrl), .wb_ctrl(wb_ctrl),
      .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .mem_req(mem_req), .wb_we(wb_we),
      .mem_error(mem_error), .stall_cycles(stall_cycles));

   ppu_pipeline_sequencer #(.MAX_WAIT(4), .HALT_ON_ERR(1'b1)) u_hlt (
      .clk(clk), .rst_n(rst_n), .id_ctrl(id_ctrl), .id_valid(id_valid), .id_squash(id_squash),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .mem_ready(mem_ready),
      .pc_le(h_pc_le), .ifid_le(h_ifid_le), .ex_ctrl(h_ex_ctrl), .mem_ctrl(h_mem_ctrl),
      .wb_ctrl(h_wb_ctrl), .ex_rd(h_ex_rd), .mem_rd(h_mem_rd), .wb_rd(h_wb_rd),
      .mem_req(h_mem_req), .wb_we(h_wb_we), .mem_error(h_mem_error),
      .stall_cycles(h_stall_cycles));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [14:0] ctrl;
      logic        v, sq;
      logic [4:0]  rs, rt, rd;
      logic        mr;
      logic        e_pc, e_mreq, e_wbwe;
      logic [14:0] e_ex, e_mem, e_wb;
      logic [4:0]  e_exrd;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic set_id(input logic [14:0] c, input logic v, input logic sq,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
      id_ctrl = c; id_valid = v; id_squash = sq; id_rs = rs; id_rt = rt; id_rd = rd;
   endtask

   task automatic next_cycle;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      set_id(NOP, F, F, 5'd0, 5'd0, 5'd0);
      mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
   endtask

   initial begin
      //            ctrl  v  sq rs     rt     rd     mr   pc mreq wbwe  ex    mem   wb    exrd
      tbl[0]  = '{ADDU, T, F, 5'd1, 5'd2, 5'd3, T,   T, F, F,   NOP,  NOP,  NOP,  5'd0};
      tbl[1]  = '{NOP,  F, F, 5'd0, 5'd0, 5'd0, T,   T, F, F,   ADDU, NOP,  NOP,  5'd3};
      tbl[2]  = '{LBU,  T, F, 5'd1, 5'd2, 5'd5, T,   T, F, F,   NOP,  ADDU, NOP,  5'd0};
      tbl[3]  = '{ADDU, T, F, 5'd5, 5'd2, 5'd6, T,   F, F, T,   LBU,  NOP,  ADDU, 5'd5};
      tbl[4]  = '{ADDU, T, F, 5'd5, 5'd2, 5'd6, T,   T, T, F,   NOP,  LBU,  NOP,  5'd0};
      tbl[5]  = '{LBU,  T, T, 5'd0, 5'd0, 5'd7, T,   T, F, T,   ADDU, NOP,  LBU,  5'd6};
      tbl[6]  = '{NOP,  F, F, 5'd0, 5'd0, 5'd0, T,   T, F, F,   NOP,  ADDU, NOP,  5'd0};
      tbl[7]  = '{LBU,  T, F, 5'd3, 5'd4, 5'd0, T,   T, F, T,   NOP,  NOP,  ADDU, 5'd0};
      tbl[8]  = '{ADDU, T, F, 5'd0, 5'd0, 5'd9, T,   T, F, F,   LBU,  NOP,  NOP,  5'd0};
      tbl[9]  = '{NOP,  F, F, 5'd0, 5'd0, 5'd0, T,   T, T, F,   ADDU, LBU,  NOP,  5'd9};
      tbl[10] = '{NOP,  F, F, 5'd0, 5'd0, 5'd0, T,   T, F, T,   NOP,  ADDU, LBU,  5'd0};

      // Reset state, observed while rst_n is still low.
      rst_n = 1'b0;
      set_id(ADDU, T, F, 5'd1, 5'd2, 5'd3);
      mem_ready = 1'b1;
      #23;
      chk("rst_ex_ctrl", 16'(ex_ctrl), 16'h0);
      chk("rst_mem_ctrl", 16'(mem_ctrl), 16'h0);
      chk("rst_wb_ctrl", 16'(wb_ctrl), 16'h0);
      chk("rst_wb_rd", 16'(wb_rd), 16'h0);
      chk("rst_mem_error", 16'(mem_error), 16'h0);
      chk("rst_stall", stall_cycles, 16'h0);
      chk("rst_wb_we", 16'(wb_we), 16'h0);
      do_reset();
      @(negedge clk);
      chk("rel_pc_le", 16'(pc_le), 16'h1);
      chk("rel_ifid_le", 16'(ifid_le), 16'h1);

      // Per-cycle table: basic flow, load-use bubble, squash, rd=0 load, zero-wait access.
      next_cycle();
      for (int i = 0; i < 11; i++) begin
         set_id(tbl[i].ctrl, tbl[i].v, tbl[i].sq, tbl[i].rs, tbl[i].rt, tbl[i].rd);
         mem_ready = tbl[i].mr;
         @(negedge clk);
         chk($sformatf("v%0d_pc_le", i), 16'(pc_le), 16'(tbl[i].e_pc));
         chk($sformatf("v%0d_mem_req", i), 16'(mem_req), 16'(tbl[i].e_mreq));
         chk($sformatf("v%0d_wb_we", i), 16'(wb_we), 16'(tbl[i].e_wbwe));
         chk($sformatf("v%0d_ex_ctrl", i), 16'(ex_ctrl), 16'(tbl[i].e_ex));
         chk($sformatf("v%0d_mem_ctrl", i), 16'(mem_ctrl), 16'(tbl[i].e_mem));
         chk($sformatf("v%0d_wb_ctrl", i), 16'(wb_ctrl), 16'(tbl[i].e_wb));
         chk($sformatf("v%0d_ex_rd", i), 16'(ex_rd), 16'(tbl[i].e_exrd));
         if (i == 10) chk("tbl_stall", stall_cycles, 16'd1);
         next_cycle();
      end

      // SB held in MEM for three not-ready cycles, then advances.
      do_reset();
      set_id(SB, T, F, 5'd1, 5'd2, 5'd0);
      next_cycle();
      set_id(ADDU, T, F, 5'd1, 5'd2, 5'd3);
      next_cycle();
      set_id(NOP, F, F, 5'd0, 5'd0, 5'd0);
      mem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("wait%0d_pc_le", k), 16'(pc_le), 16'h0);
         chk($sformatf("wait%0d_mem_req", k), 16'(mem_req), 16'h1);
         chk($sformatf("wait%0d_ex", k), 16'(ex_ctrl), 16'(ADDU));
         chk($sformatf("wait%0d_mem", k), 16'(mem_ctrl), 16'(SB));
         next_cycle();
      end
      mem_ready = 1'b1;
      @(negedge clk);
      chk("wait_done_pc_le", 16'(pc_le), 16'h1);
      next_cycle();
      @(negedge clk);
      chk("wait_adv_mem", 16'(mem_ctrl), 16'(ADDU));
      chk("wait_adv_wb", 16'(wb_ctrl), 16'(SB));
      chk("wait_adv_wb_we", 16'(wb_we), 16'h0);
      chk("wait_adv_ex", 16'(ex_ctrl), 16'h0);
      chk("wait_stall", stall_cycles, 16'd3);
      next_cycle();

      // Timeout with MAX_WAIT=4 on both the resume and the halting instance.
      do_reset();
      set_id(LBU, T, F, 5'd1, 5'd2, 5'd8);
      next_cycle();
      set_id(NOP, F, F, 5'd0, 5'd0, 5'd0);
      next_cycle();
      mem_ready = 1'b0;
      next_cycle();
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("to%0d_mem_error", k), 16'(mem_error), 16'h0);
         chk($sformatf("to%0d_mem", k), 16'(mem_ctrl), 16'(LBU));
         next_cycle();
      end
      @(negedge clk);
      chk("to_mem_error", 16'(mem_error), 16'h1);
      chk("to_wb_bubble", 16'(wb_ctrl), 16'h0);
      chk("to_wb_we", 16'(wb_we), 16'h0);
      chk("to_pc_le_resume", 16'(pc_le), 16'h1);
      chk("to_h_mem_error", 16'(h_mem_error), 16'h1);
      chk("to_h_wb_bubble", 16'(h_wb_ctrl), 16'h0);
      chk("to_h_pc_le", 16'(h_pc_le), 16'h0);
      chk("to_h_mem_req", 16'(h_mem_req), 16'h0);
      mem_ready = 1'b1;
      set_id(ADDU, T, F, 5'd1, 5'd2, 5'd3);
      next_cycle();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("halt%0d_h_pc_le", k), 16'(h_pc_le), 16'h0);
         chk($sformatf("halt%0d_h_ex", k), 16'(h_ex_ctrl), 16'h0);
         chk($sformatf("halt%0d_err_sticky", k), 16'(mem_error), 16'h1);
         next_cycle();
      end
      do_reset();
      @(negedge clk);
      chk("halt_rst_h_pc_le", 16'(h_pc_le), 16'h1);
      chk("halt_rst_h_err", 16'(h_mem_error), 16'h0);
      next_cycle();

      // Asynchronous reset in the middle of a memory wait.
      set_id(SB, T, F, 5'd1, 5'd2, 5'd0);
      next_cycle();
      set_id(NOP, F, F, 5'd0, 5'd0, 5'd0);
      next_cycle();
      mem_ready = 1'b0;
      next_cycle();
      @(negedge clk);
      chk("ar_wait_pc_le", 16'(pc_le), 16'h0);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_mem_ctrl", 16'(mem_ctrl), 16'h0);
      chk("ar_ex_ctrl", 16'(ex_ctrl), 16'h0);
      chk("ar_wb_ctrl", 16'(wb_ctrl), 16'h0);
      chk("ar_mem_req", 16'(mem_req), 16'h0);
      mem_ready = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      @(negedge clk);
      chk("ar_rel_pc_le", 16'(pc_le), 16'h1);
      chk("ar_rel_mem_req", 16'(mem_req), 16'h0);
      chk("ar_rel_wb_we", 16'(wb_we), 16'h0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
